// File: rtl/vga_fb_bus_ctrl.sv
// Memory-mapped bridge between the 8-bit processor bus and frame-buffer port A:
// X/Y cursor with optional auto-increment, pixel read/write, fill engine and colour config.
module vga_fb_bus_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int         X_BITS    = 8,
  parameter int         Y_BITS    = 7,
  parameter int         PIX_BITS  = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  inout  wire  [7:0]               BUS_DATA,
  input  logic [7:0]               BUS_ADDR,
  input  logic                     BUS_WE,
  output logic [X_BITS+Y_BITS-1:0] FB_ADDR,
  output logic [PIX_BITS-1:0]      FB_DATA,
  output logic                     FB_WE,
  input  logic [PIX_BITS-1:0]      FB_RDATA,
  output logic [15:0]              CONFIG_COLOURS,
  output logic                     BUSY
);

  localparam int A_BITS = X_BITS + Y_BITS;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [X_BITS-1:0]     r_x;
  logic [Y_BITS-1:0]     r_y;
  logic                  r_autoinc;
  logic [7:0]            r_fill_col;
  logic [7:0]            r_cfg_lo;
  logic [7:0]            r_cfg_hi;
  logic [A_BITS-1:0]     r_fb_addr;
  logic [PIX_BITS-1:0]   r_fb_data;
  logic                  r_fb_we;
  logic                  r_rd_en;
  logic [7:0]            r_rd_data;

  logic [7:0]            w_off;
  logic                  w_hit;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_busy;
  logic                  w_wr_x;
  logic                  w_wr_y;
  logic                  w_pix_wr;
  logic                  w_ctrl_wr;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_x_end;
  logic [7:0]            w_rd_val;

  // Address window check refuses to wrap past 8'hFF back to low addresses.
  assign w_off     = BUS_ADDR - BASE_ADDR;
  assign w_hit     = (BUS_ADDR >= BASE_ADDR) && (w_off < 8'd8);
  assign w_wr      = w_hit && BUS_WE;
  assign w_rd      = w_hit && !BUS_WE;
  assign w_busy    = (r_state == S_FILL);

  assign w_wr_x    = w_wr && (w_off[2:0] == 3'd0) && !w_busy;
  assign w_wr_y    = w_wr && (w_off[2:0] == 3'd1) && !w_busy;
  assign w_pix_wr  = w_wr && (w_off[2:0] == 3'd2) && !w_busy;
  assign w_ctrl_wr = w_wr && (w_off[2:0] == 3'd3);
  assign w_start   = w_ctrl_wr && BUS_DATA[1] && !w_busy;
  assign w_abort   = w_ctrl_wr && BUS_DATA[2] && w_busy;
  assign w_x_end   = (r_x == '1);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_FILL;
      S_FILL: if (w_abort || (r_fb_addr == '1)) w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (w_wr_x)                    r_x <= BUS_DATA[X_BITS-1:0];
      else if (w_pix_wr && r_autoinc) r_x <= r_x + X_BITS'(1);
      if (w_wr_y)                    r_y <= BUS_DATA[Y_BITS-1:0];
      else if (w_pix_wr && r_autoinc && w_x_end) r_y <= r_y + Y_BITS'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_autoinc  <= 1'b0;
      r_fill_col <= 8'h00;
      r_cfg_lo   <= 8'hFF;
      r_cfg_hi   <= 8'hFF;
    end else begin
      if (w_ctrl_wr && !w_busy)                          r_autoinc  <= BUS_DATA[0];
      if (w_wr && (w_off[2:0] == 3'd4) && !w_busy)       r_fill_col <= BUS_DATA;
      if (w_wr && (w_off[2:0] == 3'd6))                  r_cfg_lo   <= BUS_DATA;
      if (w_wr && (w_off[2:0] == 3'd7))                  r_cfg_hi   <= BUS_DATA;
    end
  end

  // The fill counter is the frame-buffer address register itself.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fb_addr <= '0;
      r_fb_data <= '0;
      r_fb_we   <= 1'b0;
    end else if (w_busy && (w_state_nxt == S_FILL)) begin
      r_fb_addr <= r_fb_addr + A_BITS'(1);
      r_fb_data <= r_fill_col[PIX_BITS-1:0];
      r_fb_we   <= 1'b1;
    end else if (w_start) begin
      r_fb_addr <= '0;
      r_fb_data <= r_fill_col[PIX_BITS-1:0];
      r_fb_we   <= 1'b1;
    end else if (w_pix_wr) begin
      r_fb_addr <= {r_y, r_x};
      r_fb_data <= BUS_DATA[PIX_BITS-1:0];
      r_fb_we   <= 1'b1;
    end else begin
      r_fb_addr <= {r_y, r_x};
      r_fb_we   <= 1'b0;
    end
  end

  always_comb begin
    w_rd_val = 8'h00;
    case (w_off[2:0])
      3'd0:    w_rd_val = 8'(r_x);
      3'd1:    w_rd_val = 8'(r_y);
      3'd2:    w_rd_val = 8'(FB_RDATA);
      3'd3:    w_rd_val = {w_busy, 6'b000000, r_autoinc};
      3'd4:    w_rd_val = r_fill_col;
      3'd6:    w_rd_val = r_cfg_lo;
      3'd7:    w_rd_val = r_cfg_hi;
      default: w_rd_val = 8'h00;
    endcase
  end

  // Read data is returned one cycle after the address phase.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rd_en   <= 1'b0;
      r_rd_data <= 8'h00;
    end else begin
      r_rd_en <= w_rd;
      if (w_rd) r_rd_data <= w_rd_val;
    end
  end

  assign BUS_DATA       = r_rd_en ? r_rd_data : 8'bzzzzzzzz;
  assign FB_ADDR        = r_fb_addr;
  assign FB_DATA        = r_fb_data;
  assign FB_WE          = r_fb_we;
  assign CONFIG_COLOURS = {r_cfg_hi, r_cfg_lo};
  assign BUSY           = w_busy;

endmodule

// File: doc/vga_fb_bus_ctrl.md
# vga_fb_bus_ctrl

Parametrised memory-mapped controller between the 8-bit processor bus and port A of the VGA frame buffer. Replaces the fixed 1-bit, 4-register VGA bus peripheral with:
- configurable X/Y/pixel widths;
- auto-increment pixel writes;
- pixel readback;
- a hardware fill/clear engine;
- bus-programmable CONFIG_COLOURS for the signal generator.

Sits on the data-memory bus at BASE_ADDR; its FB_* outputs drive frame-buffer port A.

## Interface

- BASE_ADDR, 8'hB0, bus address of register offset 0; occupies BASE_ADDR..BASE_ADDR+7
- X_BITS, 8, column address width (1..8)
- Y_BITS, 7, row address width (1..8)
- PIX_BITS, 1, pixel data width (1..8)

- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high
- BUS_DATA  inout  8  shared bus data; tristated unless this block is returning read data
- BUS_ADDR  in  8  bus address
- BUS_WE  in  1  1 = write, 0 = read
- FB_ADDR  out  X_BITS+Y_BITS  frame-buffer address {Y,X}, registered
- FB_DATA  out  PIX_BITS  frame-buffer write data, registered
- FB_WE  out  1  frame-buffer write strobe, registered
- FB_RDATA  in  PIX_BITS  frame-buffer synchronous read data, 1-cycle latency from FB_ADDR
- CONFIG_COLOURS  out  16  {CFG_HI, CFG_LO} to the VGA signal generator
- BUSY  out  1  fill engine active

## Operation

Register map (offsets):
- 0 X: R/W; only the low X_BITS are stored.
- 1 Y: R/W; only the low Y_BITS are stored.
- 2 PIXEL:
  - Write: issues one frame-buffer write of data[PIX_BITS-1:0] at the current {Y,X}.
  - Read: returns FB_RDATA zero-extended.
- 3 CTRL: bit0 AUTOINC (R/W); bit1 FILL_START (write-1 pulse, reads 0); bit2 ABORT (write-1 pulse, reads 0); bit7 BUSY (read-only).
- 4 FILL_COLOUR: R/W; the low PIX_BITS are used.
- 5 reserved: reads 0, writes ignored.
- 6 CFG_LO, 7 CFG_HI: R/W; drive CONFIG_COLOURS.

Auto-increment (AUTOINC=1): after each PIXEL write, X increments. At 2^X_BITS-1, X wraps to 0 and Y increments; Y wraps to 0 at 2^Y_BITS-1.

Fill FSM:
- IDLE: FILL_START=1 → FILL with counter=0.
- FILL: each cycle writes FILL_COLOUR at FB_ADDR=counter with FB_WE=1, then counter increments.
  - Last address 2^(X_BITS+Y_BITS)-1 written → IDLE.
  - ABORT write → IDLE; FB_WE=0 from the next cycle.
- X and Y are untouched by the fill.

While BUSY:
- Writes to offsets 0, 1, 2 and 4 are ignored; a CTRL write is honoured for ABORT only.
- Writes to 6 and 7 and all reads are honoured.

Bus decode:
- Hit: BUS_ADDR - BASE_ADDR < 8 (unsigned 8-bit compare, no wrap past 8'hFF).
- Miss: no state change, bus not driven.

## Timing

Reset values:
- X=0, Y=0, CTRL=0, FILL_COLOUR=0; CFG_LO=CFG_HI=8'hFF, so CONFIG_COLOURS=16'hFFFF.
- FSM=IDLE, BUSY=0, FB_WE=0, FB_ADDR=0, FB_DATA=0; BUS_DATA released.
- Reset mid-fill aborts immediately; FB_WE=0 after that edge.

Register writes: BUS_WE=1 with a hit at edge N → the register is updated at N.

PIXEL write: at edge N, FB_ADDR←{Y,X} (pre-increment), FB_DATA←data and FB_WE←1, so the write is presented during cycle N+1. Back-to-back PIXEL writes, one per cycle, are supported with no gaps.

Idle address tracking: in cycles with no pixel write and no fill, FB_ADDR←{Y,X} and FB_WE←0.

Reads: BUS_WE=0 with a hit at edge N → the read value is captured at N and driven on BUS_DATA throughout cycle N+1.
- PIXEL reads are valid only if X and Y were stable for at least 2 cycles before edge N.

FILL_START at edge N:
- BUSY=1 and first FB_WE=1 (address 0) both during cycle N+1.
- Last write during cycle N+2^(X_BITS+Y_BITS).
- BUSY=0 from the following cycle; total 32768 write cycles at defaults.

BUSY output equals CTRL bit7.

## Test plan

- Reset, then read offsets 0-7 → 0,0,0,0,0,0,FF,FF; CONFIG_COLOURS=16'hFFFF; FB_WE=0.
- X=0x10, Y=0x05, PIXEL=0x01 → one FB_WE pulse at FB_ADDR=0x0510 with FB_DATA=1; X reads 0x10.
- AUTOINC=1, X=0xFF, Y=0x7F, two PIXEL writes → writes land at 0x7FFF then 0x0000; X=1 and Y=0 afterwards.
- PIXEL_BITS=4 build: FILL_COLOUR=0xA, FILL_START:
  - 32768 consecutive FB_WE cycles, addresses 0..0x7FFF, FB_DATA=0xA;
  - BUSY falls the cycle after the last write;
  - an X write during the fill is ignored.
- Fill started, ABORT written at write #100 → FB_WE low from the next cycle; BUSY=0; a new FILL_START restarts at address 0.
- Bus read of BASE_ADDR-1 and BASE_ADDR+8 → BUS_DATA stays Z; RESET asserted mid-fill → BUSY=0 and FB_WE=0 after one edge.
